// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low segment patterns, blank enable
// constant and the scan-decoder state encoding.
package sevenseg_pkg;

  // Index is the hex value; bit0 = segment a ... bit6 = segment g, active-low.
  localparam logic [6:0] SEG_PATTERN [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0]  SEG_BLANK = '1;
  localparam logic [15:0] EN_BLANK  = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } scan_state_e;

endpackage

// File: rtl/sevenseg_scan_decoder_if.sv
// Display-bus sniffer interface: raw segment/enable lines in, decoded digits out.
interface sevenseg_scan_decoder_if #(
  parameter int unsigned DIGITS = 3
);
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   en_in;
  logic                clear;
  logic [4*DIGITS-1:0] digit_out;
  logic [DIGITS-1:0]   digit_valid;
  logic                update_pulse;
  logic                err_pulse;

  modport master (
    output seg_in, en_in, clear,
    input  digit_out, digit_valid, update_pulse, err_pulse
  );

  modport slave (
    input  seg_in, en_in, clear,
    output digit_out, digit_valid, update_pulse, err_pulse
  );
endinterface

// File: rtl/sevenseg_pattern_lookup.sv
// Combinational reverse lookup of an active-low segment pattern to its hex value.
module sevenseg_pattern_lookup
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] value
);

  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == SEG_PATTERN[i]) begin
        hit   = 1'b1;
        value = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Synchronizes, de-glitches and decodes a multiplexed active-low seven-segment
// bus back into per-digit hex values with valid flags.
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGITS        = 3,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  sevenseg_scan_decoder_if.slave bus
);

  localparam int unsigned W = DIGITS + 7;

  logic [W-1:0]        s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  scan_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] dout_q, dout_d;
  logic [DIGITS-1:0]   dval_q, dval_d;
  logic                upd_q, upd_d, err_q, err_d;

  logic                chg;
  logic                evaluate;
  logic [DIGITS-1:0]   eval_en;
  logic [6:0]          eval_seg;
  logic                one_cold;
  logic                hit;
  logic [3:0]          value;

  assign chg      = (s2_q != prev_q);
  assign eval_en  = prev_q[W-1:7];
  assign eval_seg = prev_q[6:0];
  assign one_cold = ($countones(eval_en) == int'(DIGITS - 1));

  sevenseg_pattern_lookup u_lookup (
    .seg   (eval_seg),
    .hit   (hit),
    .value (value)
  );

  always_comb begin
    s1_d     = {bus.en_in, bus.seg_in};
    s2_d     = s1_q;
    prev_d   = s2_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dval_d   = dval_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;
    evaluate = 1'b0;

    // The increment that reaches STABLE_CYCLES-1 is the edge on which the
    // STABLE_CYCLES-th identical sample is seen, so evaluation happens there.
    case (state_q)
      IDLE: begin
        if (chg) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (chg) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(STABLE_CYCLES - 1)) begin
            evaluate = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (chg) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (evaluate && (eval_en != EN_BLANK[DIGITS-1:0])) begin
      if (!one_cold || !hit) begin
        err_d = 1'b1;
      end else begin
        upd_d = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (!eval_en[i]) begin
            dout_d[4*i +: 4] = value;
            dval_d[i]        = 1'b1;
          end
        end
      end
    end

    // Clear overrides the stored digits but leaves the update strobe intact.
    if (bus.clear) begin
      dout_d = '0;
      dval_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '1;
      s2_q    <= '1;
      prev_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      dval_q  <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign bus.digit_out    = dout_q;
  assign bus.digit_valid  = dval_q;
  assign bus.update_pulse = upd_q;
  assign bus.err_pulse    = err_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Scoreboard bench for sevenseg_scan_decoder: expected pulses are queued when a
// stable pattern is driven and checked when the decoder strobes.
module tb_sevenseg_scan_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_scan_decoder_if #(.DIGITS(3)) bus ();

  sevenseg_scan_decoder #(
    .DIGITS        (3),
    .STABLE_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        is_err;
    logic [11:0] dout;
    logic [2:0]  dval;
  } ev_t;

  ev_t         sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [11:0] m_dout = '0;
  logic [2:0]  m_dval = '0;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    case (s)
      7'b1000000: return 5'h10;
      7'b1111001: return 5'h11;
      7'b0100100: return 5'h12;
      7'b0110000: return 5'h13;
      7'b0011001: return 5'h14;
      7'b0010010: return 5'h15;
      7'b0000010: return 5'h16;
      7'b1111000: return 5'h17;
      7'b0000000: return 5'h18;
      7'b0010000: return 5'h19;
      7'b0001000: return 5'h1A;
      7'b0000011: return 5'h1B;
      7'b1000110: return 5'h1C;
      7'b0100001: return 5'h1D;
      7'b0000110: return 5'h1E;
      7'b0001110: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  // Apply a new pattern at a falling edge and queue the pulse it must cause.
  task automatic drive_stable(input logic [2:0] en, input logic [6:0] seg);
    logic [4:0] d;
    ev_t e;
    @(negedge clk);
    bus.en_in  = en;
    bus.seg_in = seg;
    d = ref_decode(seg);
    if (en == 3'b111) return;
    if (en != 3'b110 && en != 3'b101 && en != 3'b011) begin
      e.is_err = 1'b1;
    end else if (!d[4]) begin
      e.is_err = 1'b1;
    end else begin
      e.is_err = 1'b0;
      for (int i = 0; i < 3; i++)
        if (!en[i]) begin
          m_dout[4*i +: 4] = d[3:0];
          m_dval[i]        = 1'b1;
        end
    end
    e.dout = m_dout;
    e.dval = m_dval;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (bus.update_pulse || bus.err_pulse)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got upd=%b err=%b dout=%h dval=%b, required no pulse",
                 bus.update_pulse, bus.err_pulse, bus.digit_out, bus.digit_valid);
      end else begin
        e = sb.pop_front();
        if ({bus.update_pulse, bus.err_pulse, bus.digit_out, bus.digit_valid} !==
            {!e.is_err, e.is_err, e.dout, e.dval}) begin
          miscompares++;
          $display("FAIL scoreboard: got upd=%b err=%b dout=%h dval=%b, required upd=%b err=%b dout=%h dval=%b",
                   bus.update_pulse, bus.err_pulse, bus.digit_out, bus.digit_valid,
                   !e.is_err, e.is_err, e.dout, e.dval);
        end
      end
    end
  end

  task automatic test_reset();
    #1;
    vectors++;
    if ({bus.digit_out, bus.digit_valid, bus.update_pulse, bus.err_pulse} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_state: got dout=%h dval=%b upd=%b err=%b, required all zero",
               bus.digit_out, bus.digit_valid, bus.update_pulse, bus.err_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_digit();
    int lat = 0;
    drive_stable(3'b110, 7'b0100100);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.update_pulse || bus.err_pulse) begin
        lat = k;
        break;
      end
    end
    vectors++;
    if (lat != 6) begin
      miscompares++;
      $display("FAIL latency: got %0d falling edges, required 6", lat);
    end
    @(negedge clk);
    vectors++;
    if (bus.update_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_width: update_pulse still %b, required 0", bus.update_pulse);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (bus.digit_out[3:0] !== 4'h2 || bus.digit_valid !== 3'b001) begin
      miscompares++;
      $display("FAIL single_digit: got dout=%h dval=%b, required nibble0=2 dval=001",
               bus.digit_out, bus.digit_valid);
    end
  endtask

  task automatic test_scan();
    drive_stable(3'b110, 7'b1111001); repeat (9) @(negedge clk);
    drive_stable(3'b101, 7'b0001000); repeat (9) @(negedge clk);
    drive_stable(3'b011, 7'b0001110); repeat (9) @(negedge clk);
    vectors++;
    if (bus.digit_out !== 12'hFA1 || bus.digit_valid !== 3'b111 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL scan: got dout=%h dval=%b pending=%0d, required dout=fa1 dval=111 pending=0",
               bus.digit_out, bus.digit_valid, sb.size());
    end
  endtask

  task automatic test_errors();
    drive_stable(3'b110, 7'b1111111); repeat (9) @(negedge clk);
    drive_stable(3'b100, 7'b0100100); repeat (9) @(negedge clk);
    vectors++;
    if (bus.digit_out !== 12'hFA1 || bus.digit_valid !== 3'b111 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL errors: got dout=%h dval=%b pending=%0d, required dout=fa1 dval=111 pending=0",
               bus.digit_out, bus.digit_valid, sb.size());
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    logic [6:0] pa = 7'b1111001;
    logic [6:0] pb = 7'b0100100;
    bus.en_in = 3'b110;
    for (int k = 0; k < 20; k++) begin
      bus.seg_in = k[0] ? pb : pa;
      repeat (2) begin
        @(negedge clk);
        if (bus.update_pulse || bus.err_pulse) pulses++;
      end
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL glitch: got %0d pulses, required 0", pulses);
    end
    drive_stable(3'b110, 7'b0000000); repeat (9) @(negedge clk);
    vectors++;
    if (bus.digit_out !== 12'hFA8 || bus.digit_valid !== 3'b111 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL glitch_recover: got dout=%h dval=%b pending=%0d, required dout=fa8 dval=111 pending=0",
               bus.digit_out, bus.digit_valid, sb.size());
    end
  endtask

  task automatic test_reset_mid_settle();
    int pulses = 0;
    @(negedge clk);
    bus.en_in  = 3'b101;
    bus.seg_in = 7'b0110000;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.digit_out, bus.digit_valid, bus.update_pulse, bus.err_pulse} !== 17'h0) begin
      miscompares++;
      $display("FAIL async_reset: got dout=%h dval=%b upd=%b err=%b, required all zero",
               bus.digit_out, bus.digit_valid, bus.update_pulse, bus.err_pulse);
    end
    sb.delete();
    m_dout = '0;
    m_dval = '0;
    bus.en_in  = 3'b111;
    bus.seg_in = 7'b1111111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.update_pulse || bus.err_pulse) pulses++;
    end
    vectors++;
    if (pulses != 0 || bus.digit_out !== 12'h000 || bus.digit_valid !== 3'b000) begin
      miscompares++;
      $display("FAIL post_reset: got pulses=%0d dout=%h dval=%b, required 0 pulses dout=000 dval=000",
               pulses, bus.digit_out, bus.digit_valid);
    end
  endtask

  task automatic test_clear_collision();
    ev_t e;
    drive_stable(3'b110, 7'b0000000); repeat (9) @(negedge clk);
    vectors++;
    if (bus.digit_out !== 12'h008 || bus.digit_valid !== 3'b001) begin
      miscompares++;
      $display("FAIL preload: got dout=%h dval=%b, required dout=008 dval=001",
               bus.digit_out, bus.digit_valid);
    end
    @(negedge clk);
    bus.en_in  = 3'b101;
    bus.seg_in = 7'b0010010;
    m_dout = '0;
    m_dval = '0;
    e.is_err = 1'b0;
    e.dout   = '0;
    e.dval   = '0;
    sb.push_back(e);
    repeat (5) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    vectors++;
    if (bus.update_pulse !== 1'b1 || bus.digit_out !== 12'h000 || bus.digit_valid !== 3'b000) begin
      miscompares++;
      $display("FAIL clear_collision: got upd=%b dout=%h dval=%b, required upd=1 dout=000 dval=000",
               bus.update_pulse, bus.digit_out, bus.digit_valid);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (sb.size() != 0 || bus.digit_valid !== 3'b000) begin
      miscompares++;
      $display("FAIL clear_drain: got pending=%0d dval=%b, required pending=0 dval=000",
               sb.size(), bus.digit_valid);
    end
  endtask

  initial begin
    bus.en_in  = 3'b111;
    bus.seg_in = 7'b1111111;
    bus.clear  = 1'b0;
    test_reset();
    test_single_digit();
    test_scan();
    test_errors();
    test_glitch();
    test_reset_mid_settle();
    test_clear_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
